// File: rtl/rr_arbiter_demux_3x8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_demux_3x8
//
// Purpose:
//   Round-robin arbiter sharing one 8-way resource among 8 requesters. The
//   winner's 3-bit index is registered. That index drives a 3-to-8 demux,
//   which produces the one-hot grant vector. A grant is held until the owner
//   signals done, drops its request, or reaches the hold limit. Exactly one
//   idle cycle separates consecutive grants.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   en         in   1  arbitration enable (only looked at while idle)
//   req        in   8  request vector, bit i = requester i
//   done       in   1  current owner releases its grant (only looked at in GRANT)
//   gnt_valid  out  1  a grant is active this cycle
//   gnt_idx    out  3  index of the current or most recent winner
//   gnt        out  8  one-hot grant, 8'h00 when no grant is active
//
// Parameters:
//   HOLD_MAX   maximum consecutive cycles one grant may be held (1..15)
//   CNT_W      hold counter width; 2**CNT_W must exceed HOLD_MAX
// -----------------------------------------------------------------------------

// 3-to-8 demux: output bit sel is driven high when en is high.
module demux_3x8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_out
            assign y[gi] = en && (sel == 3'(gi));
        end
    endgenerate
endmodule

module rr_arbiter_demux_3x8 #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_reg, state_next;
    logic [2:0]       ptr_reg, ptr_next;
    logic [2:0]       idx_reg, idx_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

    // ---------------------------------------------------------------------
    // Winner search.
    // req_rot[k] is the request of the unit k places after ptr (mod 8).
    // The lowest set bit of req_rot is therefore the round-robin winner.
    // ---------------------------------------------------------------------
    logic [7:0] req_rot;
    logic       win_found;
    logic [2:0] win_off;
    logic [2:0] win_idx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr_reg + 3'(gi)];
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        // Scan downward so the lowest set offset ends up in win_off.
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 3'(k);
            end
        end
    end

    assign win_found = |req_rot;
    assign win_idx   = ptr_reg + win_off;

    // ---------------------------------------------------------------------
    // Release condition while in GRANT.
    // Several causes may hold at the same edge. They all merge into one
    // release, so ptr advances only once.
    // ---------------------------------------------------------------------
    logic release_now;

    assign release_now = done || !req[idx_reg] || (hold_cnt_reg == HOLD_LAST);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 3'd0;
            idx_reg      <= 3'd0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            idx_reg      <= idx_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        idx_next      = idx_reg;
        hold_cnt_next = hold_cnt_reg;

        case (state_reg)
            IDLE: begin
                // With en low, nothing changes. ptr keeps its position, so
                // fairness resumes where it left off.
                if (en && win_found) begin
                    idx_next      = win_idx;
                    hold_cnt_next = '0;
                    state_next    = GRANT;
                end
            end

            GRANT: begin
                // en is not looked at here; the current grant runs to completion.
                if (release_now) begin
                    ptr_next      = idx_reg + 3'd1;   // 7 wraps to 0
                    hold_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: derived from registered state only. No path from req to gnt.
    // ---------------------------------------------------------------------
    assign gnt_valid = (state_reg == GRANT);
    assign gnt_idx   = idx_reg;

    demux_3x8 u_demux (
        .en  (gnt_valid),
        .sel (idx_reg),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_demux_3x8.sv
module tb_rr_arbiter_demux_3x8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        string      tag;
        logic       v;
        logic [2:0] idx;
        logic [7:0] g;
    } exp_t;

    exp_t sb[$];

    rr_arbiter_demux_3x8 #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the expected state for the next observation.
    task automatic expect_out(input string tag, input logic v, input logic [2:0] idx);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.idx = idx;
        e.g   = v ? (8'(1) << idx) : 8'h00;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        $display("[%0t] %s: req=%h en=%0d done=%0d -> gnt_valid=%0d gnt_idx=%0d gnt=%h",
                 $time, e.tag, req, en, done, gnt_valid, gnt_idx, gnt);
        n_asserts++;
        assert (gnt_valid === e.v) else begin
            n_fail++;
            $error("FAIL %s.gnt_valid observed=%0d expected=%0d", e.tag, gnt_valid, e.v);
        end
        n_asserts++;
        assert (gnt_idx === e.idx) else begin
            n_fail++;
            $error("FAIL %s.gnt_idx observed=%0d expected=%0d", e.tag, gnt_idx, e.idx);
        end
        n_asserts++;
        assert (gnt === e.g) else begin
            n_fail++;
            $error("FAIL %s.gnt observed=%h expected=%h", e.tag, gnt, e.g);
        end
    endtask

    // One clock transaction: the inputs are already driven. Record the
    // expectation, step past the edge, then check.
    task automatic cyc(input string tag, input logic v, input logic [2:0] idx);
        expect_out(tag, v, idx);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Check without a clock edge (used for asynchronous reset).
    task automatic check_now(input string tag, input logic v, input logic [2:0] idx);
        expect_out(tag, v, idx);
        compare_out();
    endtask

    // Watchdog: the bench must always terminate.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;

        // 1. Reset values, then idle with no requests.
        #12;
        check_now("reset", 1'b0, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) cyc("idle_no_req", 1'b0, 3'd0);

        // 2. Single request to unit 3, released by done.
        req = 8'h08;
        cyc("single_grant", 1'b1, 3'd3);
        done = 1'b1;
        cyc("single_done", 1'b0, 3'd3);
        done = 1'b0;
        req  = 8'h00;
        cyc("single_idle", 1'b0, 3'd3);

        // 3. Full rotation from ptr=0. Reset first to restart priority.
        #3 rst = 1'b1;
        #1 check_now("rot_reset", 1'b0, 3'd0);
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            done = 1'b0;
            cyc("rot_grant", 1'b1, 3'(k % 8));
            done = 1'b1;
            cyc("rot_release", 1'b0, 3'(k % 8));
        end
        done = 1'b0;
        req  = 8'h00;
        // ptr is now 1

        // 4. Move ptr to 6 via a grant to 5, then wrap 7 -> 0.
        req = 8'h20;
        cyc("skip_to5", 1'b1, 3'd5);
        done = 1'b1;
        cyc("rel5", 1'b0, 3'd5);
        done = 1'b0;
        req  = 8'h81;
        cyc("wrap_grant7", 1'b1, 3'd7);
        req = 8'h01;                       // unit 7 drops its request
        cyc("rel7_reqdrop", 1'b0, 3'd7);
        cyc("wrap_grant0", 1'b1, 3'd0);
        done = 1'b1;
        cyc("rel0", 1'b0, 3'd0);
        done = 1'b0;
        // ptr is now 1

        // 5. Hold timeout with HOLD_MAX=4, then re-grant to 4.
        req = 8'h10;
        for (int i = 0; i < 4; i++) cyc("hold_held", 1'b1, 3'd4);
        cyc("hold_timeout", 1'b0, 3'd4);
        cyc("hold_regrant", 1'b1, 3'd4);
        for (int i = 0; i < 3; i++) cyc("hold2_held", 1'b1, 3'd4);
        done = 1'b1;                       // done coincides with the timeout
        cyc("done_and_timeout", 1'b0, 3'd4);
        done = 1'b0;
        req  = 8'hFF;
        cyc("single_advance", 1'b1, 3'd5); // ptr advanced exactly once to 5

        // 6. Asynchronous reset in the middle of the grant to 5.
        #3 rst = 1'b1;
        #1 check_now("async_reset", 1'b0, 3'd0);
        #1 rst = 1'b0;
        req = 8'h21;
        cyc("after_reset_grant0", 1'b1, 3'd0);
        done = 1'b1;
        cyc("after_reset_rel", 1'b0, 3'd0);
        done = 1'b0;
        en   = 1'b0;
        req  = 8'hFF;
        for (int i = 0; i < 3; i++) cyc("en_low_idle", 1'b0, 3'd0);
        en = 1'b1;
        cyc("en_high_grant1", 1'b1, 3'd1);
        en = 1'b0;                         // en is not looked at during GRANT
        cyc("en_low_in_grant", 1'b1, 3'd1);
        done = 1'b1;
        cyc("en_low_rel", 1'b0, 3'd1);
        done = 1'b0;
        req  = 8'h00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
